// File: rtl/cmp_arb_pkg.sv
// Shared types and default sizes for the compare arbiter slice.
//   state_t    : arbiter sequencing states (IDLE -> CMP -> RESP)
//   cmp_res_t  : one-hot compare result {gt, lt, eq}
//   N_DEF/W_DEF/CW_DEF : default requester count, operand width and
//                        statistics counter width
package cmp_arb_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned W_DEF  = 8;
    localparam int unsigned CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bus between the client blocks and cmp_arbiter.
//   req_valid/req_ready : per-requester handshake (N bits each)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id              : index of the requester the result belongs to
//   rsp_gt/rsp_lt/rsp_eq: one-hot unsigned compare result
// Modports: master = client side, slave = arbiter side.
interface cmp_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) ();
    localparam int unsigned IDW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_gt;
    logic           rsp_lt;
    logic           rsp_eq;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq
    );
endinterface

// File: rtl/cmp_core.sv
// Registered W-bit unsigned magnitude compare.
//   clk, rst_n : clock, asynchronous active-low reset (result clears to 0)
//   load_i     : register a new compare of a_i/b_i
//   a_i, b_i   : operands
//   res_o      : one-hot {gt, lt, eq} once loaded, all zero after reset
module cmp_core
    import cmp_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output cmp_res_t     res_o
);

    cmp_res_t res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (load_i) begin
            res_q.gt <= (a_i > b_i);
            res_q.lt <= (a_i < b_i);
            res_q.eq <= (a_i == b_i);
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one registered compare core between N requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cmp_arbiter_if.slave (request channels in, response out)
//   busy       : high whenever a transaction is in flight (state != IDLE)
// Optional feature, macro CMP_ARB_STATS_EN:
//   stats_clr  : synchronous clear of the result counters (wins over increment)
//   cnt_gt/cnt_lt/cnt_eq : saturating counts of handshaken results per kind
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
`ifdef CMP_ARB_STATS_EN
   ,parameter int unsigned CW = CW_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    cmp_arbiter_if.slave    bus,
    output logic            busy
`ifdef CMP_ARB_STATS_EN
   ,input  logic            stats_clr,
    output logic [CW-1:0]   cnt_gt,
    output logic [CW-1:0]   cnt_lt,
    output logic [CW-1:0]   cnt_eq
`endif
);

    localparam int unsigned IDW = $clog2(N);

    // Returns {found, index}: first valid requester at or after ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   v,
                                             input logic [IDW-1:0] ptr);
        logic [IDW:0]   r;
        logic [IDW-1:0] idx;
        r = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(ptr) + k) % N);
            if (!r[IDW] && v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic           found;
    logic [IDW-1:0] grant_idx;
    logic [N-1:0]   ready;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    cmp_res_t       res;

    always_comb begin
        {found, grant_idx} = rr_pick(bus.req_valid, rr_ptr_q);
        ready = '0;
        if (state_q == IDLE && found) begin
            ready[grant_idx] = 1'b1;
        end
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = bus.req_a[i*W +: W];
                b_sel = bus.req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        a_q      <= a_sel;
                        b_q      <= b_sel;
                        id_q     <= grant_idx;
                        rr_ptr_q <= IDW'((32'(grant_idx) + 32'd1) % N);
                        state_q  <= CMP;
                    end
                end
                CMP:  state_q <= RESP;
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cmp_core #(.W(W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == CMP),
        .a_i    (a_q),
        .b_i    (b_q),
        .res_o  (res)
    );

    // The core keeps its last result after the response leaves, so the
    // flags are qualified with rsp_valid to read zero outside RESP.
    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_gt    = bus.rsp_valid & res.gt;
    assign bus.rsp_lt    = bus.rsp_valid & res.lt;
    assign bus.rsp_eq    = bus.rsp_valid & res.eq;
    assign busy          = (state_q != IDLE);

`ifdef CMP_ARB_STATS_EN
    logic [CW-1:0] cnt_gt_q, cnt_gt_d;
    logic [CW-1:0] cnt_lt_q, cnt_lt_d;
    logic [CW-1:0] cnt_eq_q, cnt_eq_d;
    logic          rsp_hs;

    assign rsp_hs = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        cnt_gt_d = cnt_gt_q;
        cnt_lt_d = cnt_lt_q;
        cnt_eq_d = cnt_eq_q;
        if (stats_clr) begin
            cnt_gt_d = '0;
            cnt_lt_d = '0;
            cnt_eq_d = '0;
        end else if (rsp_hs) begin
            if (res.gt && cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + 1'b1;
            if (res.lt && cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + 1'b1;
            if (res.eq && cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_gt_q <= '0;
            cnt_lt_q <= '0;
            cnt_eq_q <= '0;
        end else begin
            cnt_gt_q <= cnt_gt_d;
            cnt_lt_q <= cnt_lt_d;
            cnt_eq_q <= cnt_eq_d;
        end
    end

    assign cnt_gt = cnt_gt_q;
    assign cnt_lt = cnt_lt_q;
    assign cnt_eq = cnt_eq_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic done     = 1'b0;

  cmp_arbiter_if #(.N(4), .W(8)) bus ();

`ifdef CMP_ARB_STATS_EN
  logic       stats_clr;
  logic [1:0] cnt_gt;
  logic [1:0] cnt_lt;
  logic [1:0] cnt_eq;
`endif

  cmp_arbiter #(
    .N  (4),
    .W  (8)
`ifdef CMP_ARB_STATS_EN
   ,.CW (2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy)
`ifdef CMP_ARB_STATS_EN
   ,.stats_clr (stats_clr),
    .cnt_gt    (cnt_gt),
    .cnt_lt    (cnt_lt),
    .cnt_eq    (cnt_eq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: test did not complete within the wait limit");
      $finish;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a = (bus.req_a & ~(32'hFF << (8 * idx))) | ({24'h0, a} << (8 * idx));
    bus.req_b = (bus.req_b & ~(32'hFF << (8 * idx))) | ({24'h0, b} << (8 * idx));
  endtask

  task automatic do_txn(input int unsigned idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    bus.req_valid = oh;
    set_op(idx, a, b);
    #1;
    chk("txn_req_ready", bus.req_ready, oh);
    tick();
    bus.req_valid = 4'b0000;
    chk("txn_ready_drop", bus.req_ready, 4'b0000);
    chk("txn_cmp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk("txn_rsp_valid", bus.rsp_valid, 1'b1);
    chk("txn_rsp_id", bus.rsp_id, 2'(idx));
    chk("txn_rsp_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, exp);
    tick();
    chk("txn_rsp_done", bus.rsp_valid, 1'b0);
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.rsp_ready = 1'b0;
`ifdef CMP_ARB_STATS_EN
    stats_clr     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 3'b000);
    chk("rst_id", bus.rsp_id, 2'd0);
`ifdef CMP_ARB_STATS_EN
    chk("rst_cnt", {cnt_gt, cnt_lt, cnt_eq}, 6'd0);
`endif
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();

    do_txn(1, 8'h80, 8'h7F, 3'b100);
    do_txn(3, 8'hFF, 8'hFF, 3'b001);
    do_txn(3, 8'h00, 8'h01, 3'b010);

    for (int unsigned i = 0; i < 4; i++) set_op(i, 8'(i * 16), 8'h20);
    rr_exp[0] = 3'b010;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b001;
    rr_exp[3] = 3'b100;
    bus.req_valid = 4'b1111;
    #1;
    for (int unsigned g = 0; g < 5; g++) begin
      chk("rr_grant", bus.req_ready, 4'(4'b0001 << (g % 4)));
      tick();
      chk("rr_busy", busy, 1'b1);
      tick();
      chk("rr_rsp_id", bus.rsp_id, 2'(g % 4));
      chk("rr_rsp_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, rr_exp[g % 4]);
      tick();
    end
    bus.req_valid = 4'b0000;

    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    set_op(2, 8'h05, 8'h09);
    #1;
    chk("bp_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0001;
    set_op(0, 8'h33, 8'h33);
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_id", bus.rsp_id, 2'd2);
      chk("bp_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 3'b010);
      chk("bp_req_ready", bus.req_ready, 4'b0000);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", bus.rsp_valid, 1'b1);
    tick();
    chk("bp_done", bus.rsp_valid, 1'b0);
    chk("bp_next_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("bp_next_id", bus.rsp_id, 2'd0);
    chk("bp_next_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 3'b001);
    tick();

    bus.req_valid = 4'b0010;
    set_op(1, 8'h90, 8'h10);
    #1;
    chk("mr_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0000;
    chk("mr_busy_cmp", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_valid", bus.rsp_valid, 1'b0);
    chk("mr_res", {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 3'b000);
    chk("mr_id", bus.rsp_id, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      chk("mr_no_rsp", bus.rsp_valid, 1'b0);
      chk("mr_idle", busy, 1'b0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("mr_ptr_zero", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0000;
    tick();

`ifdef CMP_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr0", {cnt_gt, cnt_lt, cnt_eq}, 6'd0);
    do_txn(0, 8'h09, 8'h01, 3'b100);
    do_txn(1, 8'h44, 8'h44, 3'b001);
    do_txn(2, 8'hF0, 8'h0F, 3'b100);
    do_txn(3, 8'h10, 8'h11, 3'b010);
    do_txn(0, 8'h00, 8'h00, 3'b001);
    do_txn(1, 8'h02, 8'h01, 3'b100);
    chk("st_cnt_gt", cnt_gt, 2'd3);
    chk("st_cnt_lt", cnt_lt, 2'd1);
    chk("st_cnt_eq", cnt_eq, 2'd2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr1", {cnt_gt, cnt_lt, cnt_eq}, 6'd0);
    for (int unsigned k = 0; k < 5; k++) do_txn(k % 4, 8'h81, 8'h80, 3'b100);
    chk("st_sat_gt", cnt_gt, 2'd3);
    chk("st_sat_other", {cnt_lt, cnt_eq}, 4'd0);
`endif

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
